// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, one imem read in flight, delivers to decode over valid/ready.
// Start->req 1 cycle, ack->valid 1 cycle; holds instr while !ready. Optional halt via FETCH_CTRL_HALT_EN.
module fetch_ctrl #(
  parameter int AW = 8,
  parameter int IW = 16,
  parameter logic [IW-1:0] HALT_OPCODE = {IW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [AW-1:0] start_address_i,
  input  logic          branch_i,
  input  logic [AW-1:0] branchloc_i,
  output logic          imem_req_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic          imem_ack_i,
  input  logic [IW-1:0] imem_data_i,
  output logic [IW-1:0] instr_o,
  output logic [AW-1:0] instr_pc_o,
  output logic          instr_valid_o,
  input  logic          instr_ready_i,
  output logic          busy_o,
  output logic          halted_o
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID
`ifdef FETCH_CTRL_HALT_EN
    , HALTED
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          kill_q, kill_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [AW-1:0] instr_pc_q, instr_pc_d;
  logic          valid_q, valid_d;
  logic          halted_q, halted_d;
  logic [AW-1:0] target;

  // Branch offsets are relative to the last instruction handed to decode.
  assign target = instr_pc_q + branchloc_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    req_d      = req_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    halted_d   = halted_q;

    if (start_i) begin
      state_d  = FETCH;
      pc_d     = start_address_i;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      // An unanswered read must complete at its original address; drop its data later.
      if (req_q && !imem_ack_i) begin
        kill_d = 1'b1;
      end else begin
        kill_d = 1'b0;
        req_d  = 1'b1;
        addr_d = start_address_i;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ack_i) begin
            if (kill_q || branch_i) begin
              kill_d = 1'b0;
              pc_d   = branch_i ? target : pc_q;
              addr_d = branch_i ? target : pc_q;
            end else begin
              instr_d    = imem_data_i;
              instr_pc_d = addr_q;
              valid_d    = 1'b1;
              pc_d       = pc_q + AW'(1);
              req_d      = 1'b0;
              state_d    = VALID;
            end
          end else if (branch_i) begin
            pc_d   = target;
            kill_d = 1'b1;
          end
        end
        VALID: begin
          if (branch_i) begin
            valid_d = 1'b0;
            pc_d    = target;
            req_d   = 1'b1;
            addr_d  = target;
            state_d = FETCH;
          end else if (instr_ready_i) begin
            valid_d = 1'b0;
`ifdef FETCH_CTRL_HALT_EN
            if (instr_q == HALT_OPCODE) begin
              state_d  = HALTED;
              halted_d = 1'b1;
            end else begin
              req_d   = 1'b1;
              addr_d  = pc_q;
              state_d = FETCH;
            end
`else
            req_d   = 1'b1;
            addr_d  = pc_q;
            state_d = FETCH;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      kill_q     <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = valid_q;
  assign busy_o        = (state_q == FETCH) || (state_q == VALID);

`ifdef FETCH_CTRL_HALT_EN
  assign halted_o = halted_q;
`else
  logic unused_halt;
  assign unused_halt = halted_q ^ (^HALT_OPCODE);
  assign halted_o    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, streaming, branch redirects, kill of stale reads, wrap, halt.
module tb_fetch_ctrl;
  localparam int AW = 8;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [AW-1:0] start_address_i;
  logic          branch_i;
  logic [AW-1:0] branchloc_i;
  logic          imem_req_o;
  logic [AW-1:0] imem_addr_o;
  logic          imem_ack_i;
  logic [IW-1:0] imem_data_i;
  logic [IW-1:0] instr_o;
  logic [AW-1:0] instr_pc_o;
  logic          instr_valid_o;
  logic          instr_ready_i;
  logic          busy_o;
  logic          halted_o;

  logic auto_ack;
  logic man_ack;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_ctrl #(.AW(AW), .IW(IW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .start_address_i (start_address_i),
    .branch_i        (branch_i),
    .branchloc_i     (branchloc_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_data_i     (imem_data_i),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .busy_o          (busy_o),
    .halted_o        (halted_o)
  );

  always #5 clk = ~clk;

  // Memory image: halt opcode at 0x05, otherwise {~addr, addr}.
  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return (a == 8'h05) ? 16'hFFFF : {~a, a};
  endfunction

  assign imem_data_i = mem_word(imem_addr_o);
  assign imem_ack_i  = auto_ack ? imem_req_o : man_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag, input logic [AW-1:0] exp_addr);
    int n = 0;
    while (!imem_req_o && n < 4) begin
      tick();
      n++;
    end
    check({tag, "_req"}, 32'(imem_req_o), 32'd1);
    check({tag, "_addr"}, 32'(imem_addr_o), 32'(exp_addr));
  endtask

  task automatic do_start(input logic [AW-1:0] a);
    start_i         = 1'b1;
    start_address_i = a;
    tick();
    start_i         = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start_i = 1'b0; start_address_i = '0; branch_i = 1'b0;
    branchloc_i = '0; auto_ack = 1'b0; man_ack = 1'b0; instr_ready_i = 1'b0;
    repeat (2) tick();
    check("rst_req",      32'(imem_req_o),    32'd0);
    check("rst_addr",     32'(imem_addr_o),   32'd0);
    check("rst_valid",    32'(instr_valid_o), 32'd0);
    check("rst_instr",    32'(instr_o),       32'd0);
    check("rst_instr_pc", 32'(instr_pc_o),    32'd0);
    check("rst_busy",     32'(busy_o),        32'd0);
    check("rst_halted",   32'(halted_o),      32'd0);

    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_no_req",  32'(imem_req_o), 32'd0);
    check("idle_busy",    32'(busy_o),     32'd0);

    // Reset while a read is outstanding.
    do_start(8'h40);
    check("mid_req",      32'(imem_req_o),  32'd1);
    check("mid_addr",     32'(imem_addr_o), 32'h40);
    tick();
    check("mid_hold",     32'(imem_addr_o), 32'h40);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req",  32'(imem_req_o),  32'd0);
    check("mid_rst_addr", 32'(imem_addr_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o),      32'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("post_rst_req", 32'(imem_req_o),  32'd0);

    // Streaming from 0x10 with zero-wait memory and decode.
    auto_ack = 1'b1; instr_ready_i = 1'b1;
    do_start(8'h10);
    for (int k = 0; k < 3; k++) begin
      logic [AW-1:0] a;
      a = 8'(16 + k);
      check("seq_req",      32'(imem_req_o),    32'd1);
      check("seq_addr",     32'(imem_addr_o),   32'(a));
      check("seq_novalid",  32'(instr_valid_o), 32'd0);
      tick();
      check("seq_valid",    32'(instr_valid_o), 32'd1);
      check("seq_pc",       32'(instr_pc_o),    32'(a));
      check("seq_instr",    32'(instr_o),       32'(mem_word(a)));
      check("seq_req_low",  32'(imem_req_o),    32'd0);
      if (k == 2) instr_ready_i = 1'b0;
      tick();
    end
    check("stall_valid", 32'(instr_valid_o), 32'd1);
    check("stall_instr", 32'(instr_o),       32'hED12);
    check("stall_req",   32'(imem_req_o),    32'd0);

    // Branch from VALID: 0x20 + 0xFE wraps to 0x1E.
    do_start(8'h20);
    tick();
    check("bv_pc", 32'(instr_pc_o), 32'h20);
    branch_i = 1'b1; branchloc_i = 8'hFE;
    tick();
    branch_i = 1'b0;
    check("bv_drop_valid", 32'(instr_valid_o), 32'd0);
    wait_req("bv", 8'h1E);
    tick();
    check("bv_tgt_valid", 32'(instr_valid_o), 32'd1);
    check("bv_tgt_pc",    32'(instr_pc_o),    32'h1E);
    check("bv_tgt_instr", 32'(instr_o),       32'hE11E);

    // Branch while the read at 0x31 is outstanding; ack arrives three cycles later.
    instr_ready_i = 1'b1;
    do_start(8'h30);
    tick();
    check("bk_pc30", 32'(instr_pc_o), 32'h30);
    auto_ack = 1'b0;
    tick();
    check("bk_req",  32'(imem_req_o),  32'd1);
    check("bk_addr", 32'(imem_addr_o), 32'h31);
    branch_i = 1'b1; branchloc_i = 8'h05;
    tick();
    branch_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("bk_hold_addr", 32'(imem_addr_o),   32'h31);
      check("bk_no_valid",  32'(instr_valid_o), 32'd0);
      if (c == 2) man_ack = 1'b1;
      tick();
    end
    man_ack = 1'b0;
    check("bk_stale_dropped", 32'(instr_valid_o), 32'd0);
    check("bk_retarget_req",  32'(imem_req_o),    32'd1);
    check("bk_retarget_addr", 32'(imem_addr_o),   32'h35);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0; instr_ready_i = 1'b0;
    check("bk_valid", 32'(instr_valid_o), 32'd1);
    check("bk_pc",    32'(instr_pc_o),    32'h35);
    check("bk_instr", 32'(instr_o),       32'hCA35);

    // PC wrap after 0xFF, then start and branch together.
    auto_ack = 1'b1; instr_ready_i = 1'b1;
    do_start(8'hFF);
    tick();
    check("wrap_pc_ff", 32'(instr_pc_o), 32'hFF);
    tick();
    check("wrap_req",  32'(imem_req_o),  32'd1);
    check("wrap_addr", 32'(imem_addr_o), 32'h00);
    branch_i = 1'b1; branchloc_i = 8'h10;
    do_start(8'h80);
    branch_i = 1'b0;
    check("sb_addr",  32'(imem_addr_o),   32'h80);
    check("sb_valid", 32'(instr_valid_o), 32'd0);
    instr_ready_i = 1'b0;
    tick();
    check("sb_pc",    32'(instr_pc_o),    32'h80);
    check("sb_instr", 32'(instr_o),       32'h7F80);

    // Halt opcode at 0x05.
    do_start(8'h05);
    tick();
    check("halt_instr",  32'(instr_o),    32'hFFFF);
    check("halt_pre",    32'(halted_o),   32'd0);
    instr_ready_i = 1'b1;
    tick();
`ifdef FETCH_CTRL_HALT_EN
    check("halt_flag",   32'(halted_o),      32'd1);
    check("halt_no_req", 32'(imem_req_o),    32'd0);
    check("halt_busy",   32'(busy_o),        32'd0);
    check("halt_valid",  32'(instr_valid_o), 32'd0);
    branch_i = 1'b1; branchloc_i = 8'h03;
    tick();
    branch_i = 1'b0;
    check("halt_br_ign", 32'(imem_req_o),    32'd0);
    check("halt_stay",   32'(halted_o),      32'd1);
    do_start(8'h60);
    check("resume_req",  32'(imem_req_o),    32'd1);
    check("resume_addr", 32'(imem_addr_o),   32'h60);
    check("resume_flag", 32'(halted_o),      32'd0);
`else
    check("nohalt_flag", 32'(halted_o),      32'd0);
    check("nohalt_req",  32'(imem_req_o),    32'd1);
    check("nohalt_addr", 32'(imem_addr_o),   32'h06);
    check("nohalt_busy", 32'(busy_o),        32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
